// File: rtl/spi_byte_link_if.sv
// Byte-level handshake between the SPI slave front end and the command decoder.
// The link drives the receive strobes and transmit status; the decoder supplies reply bytes.
interface spi_byte_link_if;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic [7:0] rx_index;
  logic       msg_start;
  logic       msg_end;
  logic [7:0] tx_byte;
  logic       tx_load;
  logic       tx_ready;
  logic       tx_underrun;

  modport slave (
    output rx_byte, rx_valid, rx_index, msg_start, msg_end, tx_ready, tx_underrun,
    input  tx_byte, tx_load
  );

  modport master (
    input  rx_byte, rx_valid, rx_index, msg_start, msg_end, tx_ready, tx_underrun,
    output tx_byte, tx_load
  );
endinterface

// File: rtl/spi_byte_link.sv
// SPI mode-0 slave front end: synchronises the SPI pins into clk, assembles received bytes
// and serialises reply bytes from a one-entry holding register at byte boundaries.
module spi_byte_link #(
  parameter int         SYNC_STAGES = 3,
  parameter logic [7:0] IDLE_FILL   = 8'h00
) (
  input  logic clk,
  input  logic reset,
  input  logic SCK,
  input  logic MOSI,
  input  logic CS,
  output logic MISO,
  spi_byte_link_if.slave link
);

  if (SYNC_STAGES < 3) begin : g_bad_sync
    $error("spi_byte_link: SYNC_STAGES must be at least 3");
  end

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [1:0]             mosi_sync;

  logic       sck_rise;
  logic       sck_fall;
  logic       cs_fall;
  logic       cs_rise;
  logic       cs_active;
  logic       boundary_load;

  logic [7:0] rx_shift;
  logic [2:0] bit_cnt;
  logic       byte_done;
  logic       boundary_pend;
  logic [7:0] byte_cnt;
  logic [7:0] tx_shift;
  logic [7:0] hold;

  // Edges come from the two oldest synchroniser stages; index 0 is the newest sample.
  assign sck_rise  = ~sck_sync[SYNC_STAGES-1] &  sck_sync[SYNC_STAGES-2];
  assign sck_fall  =  sck_sync[SYNC_STAGES-1] & ~sck_sync[SYNC_STAGES-2];
  assign cs_fall   =  cs_sync[SYNC_STAGES-1]  & ~cs_sync[SYNC_STAGES-2];
  assign cs_rise   = ~cs_sync[SYNC_STAGES-1]  &  cs_sync[SYNC_STAGES-2];
  assign cs_active = ~cs_sync[1];

  // A reply byte is taken at message start and on the falling edge that closes each byte.
  assign boundary_load = cs_active & (cs_fall | (sck_fall & boundary_pend));

  assign MISO = cs_active ? tx_shift[7] : 1'bz;

  always_ff @(posedge clk) begin
    if (reset) begin
      sck_sync         <= '1;
      cs_sync          <= '1;
      mosi_sync        <= '0;
      rx_shift         <= '0;
      bit_cnt          <= '0;
      byte_done        <= 1'b0;
      boundary_pend    <= 1'b0;
      byte_cnt         <= '0;
      tx_shift         <= '0;
      hold             <= '0;
      link.rx_byte     <= '0;
      link.rx_valid    <= 1'b0;
      link.rx_index    <= '0;
      link.msg_start   <= 1'b0;
      link.msg_end     <= 1'b0;
      link.tx_ready    <= 1'b1;
      link.tx_underrun <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], SCK};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], CS};
      mosi_sync <= {mosi_sync[0], MOSI};

      link.msg_start   <= cs_fall;
      link.msg_end     <= cs_rise;
      link.rx_valid    <= 1'b0;
      link.tx_underrun <= 1'b0;
      byte_done        <= 1'b0;

      if (!cs_active) begin
        bit_cnt       <= '0;
        boundary_pend <= 1'b0;
      end else if (sck_rise) begin
        rx_shift <= {rx_shift[6:0], mosi_sync[1]};
        bit_cnt  <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          byte_done     <= 1'b1;
          boundary_pend <= 1'b1;
        end
      end else if (boundary_load) begin
        boundary_pend <= 1'b0;
      end

      // Completed byte is published one cycle after the 8th rising edge.
      if (byte_done) begin
        link.rx_byte  <= rx_shift;
        link.rx_valid <= 1'b1;
        link.rx_index <= byte_cnt;
      end

      if (!cs_active) begin
        byte_cnt <= '0;
      end else if (byte_done && byte_cnt != 8'hFF) begin
        byte_cnt <= byte_cnt + 8'd1;
      end

      if (!cs_active) begin
        tx_shift <= '0;
      end else if (boundary_load) begin
        if (!link.tx_ready) begin
          tx_shift <= hold;
        end else begin
          tx_shift         <= IDLE_FILL;
          link.tx_underrun <= 1'b1;
        end
      end else if (sck_fall) begin
        tx_shift <= {tx_shift[6:0], 1'b0};
      end

      // A load landing on a boundary with an empty register refills it for the next byte.
      if (link.tx_load && link.tx_ready) begin
        hold          <= link.tx_byte;
        link.tx_ready <= 1'b0;
      end else if (boundary_load && !link.tx_ready) begin
        link.tx_ready <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_byte_link.sv
// Bench for spi_byte_link: an SPI mode-0 master model drives messages while a byte-level
// reference (expected byte queue, holding-register model, strobe counts) checks the outputs.
module tb_spi_byte_link;
  localparam logic [7:0] FILL = 8'h00;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic sck   = 1'b0;
  logic mosi  = 1'b0;
  logic cs    = 1'b1;
  wire  miso_w;

  pullup (miso_w);

  spi_byte_link_if link ();

  spi_byte_link #(.SYNC_STAGES(3), .IDLE_FILL(FILL)) dut (
    .clk   (clk),
    .reset (reset),
    .SCK   (sck),
    .MOSI  (mosi),
    .CS    (cs),
    .MISO  (miso_w),
    .link  (link)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] mbytes [300];
  logic [7:0] rply   [300];
  logic [7:0] rdupv  [300];
  logic [7:0] cap    [300];
  bit         rpres  [300];
  bit         rdup   [300];

  logic [7:0] exp_b [$];
  int         exp_i [$];
  int exp_start = 0, exp_end = 0, exp_under = 0;
  int act_start = 0, act_end = 0, act_under = 0, act_rx = 0, rd = 0;
  logic [7:0] model_last = 8'h00;

  bit         hold_full = 1'b0;
  logic [7:0] hold_val  = 8'h00;
  logic [7:0] cur_tx    = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Per-cycle compare against the byte-level expectations.
  always @(negedge clk) begin
    if (reset) begin
      model_last = 8'h00;
    end else begin
      if (link.rx_valid) begin
        act_rx++;
        check("rx_valid_expected", rd < exp_b.size(), 1);
        if (rd < exp_b.size()) begin
          check("rx_byte", link.rx_byte, exp_b[rd]);
          check("rx_index", link.rx_index, exp_i[rd]);
          model_last = exp_b[rd];
          rd++;
        end
      end else begin
        check("rx_byte_hold", link.rx_byte, model_last);
      end
      if (link.msg_start) begin
        act_start++;
        check("msg_start_expected", act_start <= exp_start, 1);
      end
      if (link.msg_end) begin
        act_end++;
        check("msg_end_expected", act_end <= exp_end, 1);
      end
      if (link.tx_underrun) begin
        act_under++;
        check("tx_underrun_expected", act_under <= exp_under, 1);
      end
      check("start_end_exclusive", link.msg_start & link.msg_end, 0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic try_load(input logic [7:0] v);
    check("tx_ready_before_load", link.tx_ready, !hold_full);
    link.tx_byte = v;
    link.tx_load = 1'b1;
    tick(1);
    link.tx_load = 1'b0;
    if (!hold_full) begin
      hold_full = 1'b1;
      hold_val  = v;
    end
  endtask

  task automatic boundary();
    if (hold_full) begin
      cur_tx    = hold_val;
      hold_full = 1'b0;
    end else begin
      cur_tx = FILL;
      exp_under++;
    end
  endtask

  task automatic end_checks();
    check("msg_start_count", act_start, exp_start);
    check("msg_end_count", act_end, exp_end);
    check("tx_underrun_count", act_under, exp_under);
    check("rx_valid_count", rd, exp_b.size());
    check("miso_hiz_idle", miso_w, 1'b1);
  endtask

  task automatic reset_checks();
    check("rst_rx_byte", link.rx_byte, 0);
    check("rst_rx_index", link.rx_index, 0);
    check("rst_rx_valid", link.rx_valid, 0);
    check("rst_msg_start", link.msg_start, 0);
    check("rst_msg_end", link.msg_end, 0);
    check("rst_tx_ready", link.tx_ready, 1);
    check("rst_tx_underrun", link.tx_underrun, 0);
    check("rst_miso_hiz", miso_w, 1'b1);
  endtask

  task automatic clear_tx(input int n);
    for (int i = 0; i < n; i++) begin
      rpres[i] = 1'b0;
      rdup[i]  = 1'b0;
    end
  endtask

  // phase 0: reply for byte k+1 loaded on bit 4 of byte k; phase 1: after byte k's rx_valid.
  task automatic send_msg(input int n, input int abort_at, input int reset_at, input int phase);
    int g;
    int used;
    g = 0;
    if (rpres[0]) try_load(rply[0]);
    tick(2);
    cs = 1'b0;
    exp_start++;
    boundary();
    tick(8);
    check("tx_ready_after_start", link.tx_ready, !hold_full);
    for (int k = 0; k < n; k++) begin
      for (int j = 0; j < 8; j++) begin
        mosi = mbytes[k][7-j];
        tick(5);
        sck = 1'b1;
        g++;
        cap[k][7-j] = miso_w;
        check("miso_bit", miso_w, cur_tx[7-j]);
        used = 0;
        if (j == 7) begin
          exp_b.push_back(mbytes[k]);
          exp_i.push_back(k > 255 ? 255 : k);
        end
        if (k + 1 < n && ((phase == 0 && j == 3) || (phase == 1 && j == 7))) begin
          if (phase == 1) begin
            tick(4);
            used = 4;
          end
          if (rpres[k+1]) begin
            try_load(rply[k+1]);
            used++;
          end
          if (rdup[k+1]) begin
            try_load(rdupv[k+1]);
            used++;
          end
        end
        if (used < 5) tick(5 - used);
        if (abort_at == g) begin
          sck = 1'b0;
          tick(5);
          cs = 1'b1;
          exp_end++;
          tick(10);
          end_checks();
          return;
        end
        if (reset_at == g) begin
          reset = 1'b1;
          tick(2);
          cs  = 1'b1;
          sck = 1'b0;
          tick(2);
          reset     = 1'b0;
          hold_full = 1'b0;
          tick(10);
          reset_checks();
          end_checks();
          return;
        end
        if (!(k == n - 1 && j == 7)) begin
          sck = 1'b0;
          if (j == 7) boundary();
        end
      end
    end
    // CS is released while SCK is still high, so the trailing fall is outside the message.
    tick(5);
    cs = 1'b1;
    exp_end++;
    tick(3);
    sck = 1'b0;
    tick(10);
    end_checks();
  endtask

  int b_rx, b_st, b_en, b_un;

  task automatic snap();
    b_rx = act_rx;
    b_st = act_start;
    b_en = act_end;
    b_un = act_under;
  endtask

  initial begin
    int n, ab, ph;
    link.tx_byte = 8'h00;
    link.tx_load = 1'b0;
    tick(5);
    reset = 1'b0;
    tick(5);
    reset_checks();

    // Single byte A5, no reply loaded.
    clear_tx(4);
    mbytes[0] = 8'hA5;
    snap();
    send_msg(1, -1, -1, 0);
    check("t1_rx_byte", link.rx_byte, 8'hA5);
    check("t1_rx_index", link.rx_index, 0);
    check("t1_rx_count", act_rx - b_rx, 1);
    check("t1_start_count", act_start - b_st, 1);
    check("t1_end_count", act_end - b_en, 1);

    // Three-byte message.
    clear_tx(4);
    mbytes[0] = 8'h0F; mbytes[1] = 8'h03; mbytes[2] = 8'h55;
    snap();
    send_msg(3, -1, -1, 0);
    check("t2_rx_byte", link.rx_byte, 8'h55);
    check("t2_rx_index", link.rx_index, 2);
    check("t2_rx_count", act_rx - b_rx, 3);

    // Preloaded AF, two bytes clocked.
    clear_tx(4);
    rpres[0] = 1'b1; rply[0] = 8'hAF;
    mbytes[0] = 8'h12; mbytes[1] = 8'h34;
    snap();
    send_msg(2, -1, -1, 0);
    check("t3_miso_byte0", cap[0], 8'hAF);
    check("t3_miso_byte1", cap[1], 8'h00);
    check("t3_underruns", act_under - b_un, 1);

    // Load 3C after byte 0's rx_valid, then a dropped second load of 99.
    clear_tx(4);
    rpres[1] = 1'b1; rply[1] = 8'h3C;
    rdup[1]  = 1'b1; rdupv[1] = 8'h99;
    mbytes[0] = 8'hDE; mbytes[1] = 8'hAD;
    send_msg(2, -1, -1, 1);
    check("t4_miso_byte1", cap[1], 8'h3C);
    check("t4_tx_ready_after", link.tx_ready, 1);

    // CS released after 5 bits, then a clean message.
    clear_tx(4);
    mbytes[0] = 8'hC3;
    snap();
    send_msg(1, 5, -1, 0);
    check("t5_no_rx_valid", act_rx - b_rx, 0);
    check("t5_end_count", act_end - b_en, 1);
    mbytes[0] = 8'h81;
    send_msg(1, -1, -1, 0);
    check("t5_rx_byte", link.rx_byte, 8'h81);
    check("t5_rx_index", link.rx_index, 0);

    // Reset pulsed after bit 4, then a full message.
    clear_tx(4);
    rpres[0] = 1'b1; rply[0] = 8'h5A;
    rpres[1] = 1'b1; rply[1] = 8'hE7;
    mbytes[0] = 8'h6B; mbytes[1] = 8'h2D;
    send_msg(2, -1, 4, 0);
    clear_tx(4);
    rpres[0] = 1'b1; rply[0] = 8'h96;
    mbytes[0] = 8'h4E; mbytes[1] = 8'hB1;
    send_msg(2, -1, -1, 0);
    check("t6_miso_byte0", cap[0], 8'h96);
    check("t6_rx_byte", link.rx_byte, 8'hB1);

    // Randomised messages.
    for (int m = 0; m < 14; m++) begin
      n  = $urandom_range(1, 6);
      ph = $urandom_range(0, 1);
      for (int i = 0; i < n; i++) begin
        mbytes[i] = 8'($urandom);
        rply[i]   = 8'($urandom);
        rdupv[i]  = 8'($urandom);
        rpres[i]  = ($urandom_range(0, 3) != 0);
        rdup[i]   = ($urandom_range(0, 3) == 0);
      end
      ab = -1;
      if ($urandom_range(0, 3) == 0) begin
        ab = $urandom_range(1, 8 * n - 1);
        if (ab % 8 == 0) ab = ab - 1;
      end
      send_msg(n, ab, -1, ph);
    end

    // Long message: rx_index saturates at 255.
    for (int i = 0; i < 258; i++) begin
      mbytes[i] = 8'($urandom);
      rply[i]   = 8'($urandom);
      rpres[i]  = 1'b1;
      rdup[i]   = 1'b0;
    end
    send_msg(258, -1, -1, 0);
    check("sat_rx_index", link.rx_index, 255);
    check("sat_rx_byte", link.rx_byte, mbytes[257]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_byte_link.md
Name: spi_byte_link

Overview:
- SPI slave front end (mode 0, MSB first) between the ESP32 SPI master and the FPGA command decoder.
- Synchronises SCK/CS/MOSI into the system clock domain and assembles received bytes.
- Emits one-cycle byte and message strobes, plus the byte's index within the message.
- Serialises reply bytes from a one-entry transmit holding register, so the decoder handles whole bytes and never touches SPI edge timing.

Parameters:
- SYNC_STAGES, 3: flops in each SCK/CS synchroniser chain; edges are detected on the two oldest stages. Minimum 3.
- IDLE_FILL, 8'h00: byte shifted out when the transmit holding register is empty at a byte boundary.

Ports:
- clk  in  1  system clock, 100 MHz PLL output; must be ≥ 8× the SCK frequency.
- reset  in  1  synchronous, active-high reset.
- SCK  in  1  SPI clock from the ESP32, asynchronous.
- MOSI  in  1  SPI data in, asynchronous; 2-flop synchronised.
- CS  in  1  SPI chip select, active low, asynchronous.
- MISO  out  1  SPI data out; high-Z whenever the synchronised CS is inactive.
- rx_byte  out  8  last completed received byte; holds its value until the next completed byte.
- rx_valid  out  1  one-cycle strobe: rx_byte/rx_index are new.
- rx_index  out  8  0-based position of rx_byte within the current message; saturates at 255.
- msg_start  out  1  one-cycle strobe on the synchronised CS falling edge.
- msg_end  out  1  one-cycle strobe on the synchronised CS rising edge.
- tx_byte  in  8  reply byte.
- tx_load  in  1  write tx_byte into the holding register; accepted only when tx_ready=1.
- tx_ready  out  1  holding register empty.
- tx_underrun  out  1  one-cycle strobe: IDLE_FILL was used at a byte boundary.

Behaviour:

Clock and reset
- One clock, clk.
- Reset is synchronous and active-high on port reset. The polarity and synchronicity are fixed.

Reset values
- rx_byte=0, rx_valid=0, rx_index=0, msg_start=0, msg_end=0, tx_ready=1, tx_underrun=0.
- Shift registers=0, bit counter=0, synchroniser chains all 1.
- As a consequence, MISO is high-Z and no spurious msg_start occurs.

Edge detection
- SCK rising edge = chain[top:top-1]==01; falling edge = 10.
- CS_active = ~chain[1].
- Edge-to-action latency: SYNC_STAGES cycles.

Receive path
- On each SCK rising edge with CS_active: rx_shift <= {rx_shift[6:0], MOSI_sync}; bitcnt++.
- On the 8th rising edge (bitcnt==7): the next cycle, rx_byte <= completed byte and rx_valid=1 for one cycle.
- rx_index on that strobe = number of bytes previously completed in this message. The internal byte counter increments after the strobe and saturates at 255.
- While CS is inactive: bitcnt=0 and the byte counter=0.

Transmit path
- Holding register:
  - tx_load with tx_ready=1 → hold <= tx_byte; tx_ready <= 0.
  - tx_load with tx_ready=0 is ignored; the held byte is kept.
- Byte boundary loads, into the tx shift register:
  - On msg_start: load from the holding register if full, otherwise IDLE_FILL with a tx_underrun pulse. MISO=shift[7] before the first rising edge.
  - On the first SCK falling edge after the 8th rising edge (bitcnt==0): same load rule.
  - On other falling edges with CS_active: shift left, filling with 0.
- Each load from the holding register sets tx_ready <= 1 the same cycle.
- Simultaneous tx_load and byte-boundary load in the same cycle: the boundary load uses the old holding contents (empty → IDLE_FILL). The new byte is written into the holding register for the next boundary. tx_ready stays 0.

CS deasserted mid-byte
- Partial byte discarded: no rx_valid.
- msg_end pulses; bitcnt cleared.
- tx shift register cleared; the holding register is retained.

Other boundary conditions
- SCK edges while CS is inactive are ignored entirely.
- msg_start and msg_end never coincide: each requires a CS transition detected on distinct cycles.
- Reset asserted mid-message: all state returns to reset values. No strobes fire until the next CS falling edge after reset deasserts.

Test Plan:
- Reset, then CS low, clock 0xA5 with SCK at 10 MHz, CS high → exactly one rx_valid with rx_byte=A5, rx_index=0; one msg_start; one msg_end; no other strobes.
- Message of 0x0F,0x03,0x55 → three rx_valid pulses with rx_index 0,1,2 and rx_byte 0F,03,55 in order.
- tx_load 0xAF before CS low; master clocks 2 bytes → MISO bits 10101111 then 00000000. tx_underrun pulses once, at the 2nd boundary; tx_ready returns to 1 at msg_start.
- After rx_valid of byte 0, load 0x3C while tx_ready=1; attempt a second load of 0x99 before the boundary → byte 1 on MISO = 0x3C; 0x99 is dropped.
- CS released after 5 bits → no rx_valid, msg_end=1. The next message's first byte 0x81 is received correctly with rx_index=0.
- reset pulsed after bit 4 of a byte → outputs at reset values, MISO high-Z. The next full message decodes correctly.
